// File: rtl/icon_operand_requester.sv
// Operand fetch initiator on the execution-unit interconnect tx port.
// Takes one fetch command at a time, requests up to two operands from the
// producer EU one after the other, and hands the collected pair to the ALU
// stage as a single bundle. Each operand gets a bounded number of request
// cycles; running out of them ends the fetch with an error flag.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a fetch command
//   REQ0  | requesting operand 0 at the latched src0 address
//   REQ1  | requesting operand 1 at the latched src1 address
//   DONE  | bundle valid, waiting for the consumer to take it
module icon_operand_requester #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [ADDR_W-1:0] fetch_src0_addr_i,
  input  logic [ADDR_W-1:0] fetch_src1_addr_i,
  input  logic              fetch_src1_used_i,
  output logic [ADDR_W-1:0] icon_tx_addr_o,
  output logic              icon_tx_req_valid_o,
  input  logic [DATA_W-1:0] icon_tx_data_i,
  input  logic              icon_tx_success_i,
  output logic [DATA_W-1:0] op0_data_o,
  output logic [DATA_W-1:0] op1_data_o,
  output logic              ops_valid_o,
  output logic              ops_err_o,
  input  logic              ops_ready_i
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] src0_q, src0_d;
  logic [ADDR_W-1:0] src1_q, src1_d;
  logic              src1_used_q, src1_used_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic              tx_req_q, tx_req_d;
  logic [DATA_W-1:0] op0_q, op0_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              xfer;

  // success only counts while our request is actually on the port
  assign xfer = tx_req_q & icon_tx_success_i;

  // next-state, operand capture and wait-counter logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src0_d      = src0_q;
    src1_d      = src1_q;
    src1_used_d = src1_used_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_valid_i) begin
          src0_d      = fetch_src0_addr_i;
          src1_d      = fetch_src1_addr_i;
          src1_used_d = fetch_src1_used_i;
          op0_d       = '0;
          op1_d       = '0;
          err_d       = 1'b0;
          cnt_d       = '0;
          state_d     = REQ0;
        end
      end
      REQ0: begin
        if (xfer) begin
          op0_d   = icon_tx_data_i;
          cnt_d   = '0;
          state_d = src1_used_q ? REQ1 : DONE;
        end else if (cnt_q == CNT_LAST) begin
          // abort the whole fetch; operand 1 is never requested
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      REQ1: begin
        if (xfer) begin
          op1_d   = icon_tx_data_i;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DONE: begin
        if (ops_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // flush wins over everything, including a transfer in the same cycle
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      src0_d      = src0_q;
      src1_d      = src1_q;
      src1_used_d = src1_used_q;
      op0_d       = op0_q;
      op1_d       = op1_q;
      err_d       = err_q;
    end
  end

  // port outputs are registered and derived from the upcoming state
  always_comb begin
    tx_req_d  = (state_d == REQ0) || (state_d == REQ1);
    valid_d   = (state_d == DONE);
    tx_addr_d = '0;
    if (state_d == REQ0) tx_addr_d = src0_d;
    else if (state_d == REQ1) tx_addr_d = src1_d;
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src0_q      <= '0;
      src1_q      <= '0;
      src1_used_q <= 1'b0;
      tx_addr_q   <= '0;
      tx_req_q    <= 1'b0;
      op0_q       <= '0;
      op1_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      src1_used_q <= src1_used_d;
      tx_addr_q   <= tx_addr_d;
      tx_req_q    <= tx_req_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign fetch_ready_o       = (state_q == IDLE);
  assign icon_tx_addr_o      = tx_addr_q;
  assign icon_tx_req_valid_o = tx_req_q;
  assign op0_data_o          = op0_q;
  assign op1_data_o          = op1_q;
  assign ops_valid_o         = valid_q;
  assign ops_err_o           = err_q;

endmodule

// File: tb/tb_icon_operand_requester.sv
// Directed bench for icon_operand_requester: zero-wait, stalled, timeout,
// backpressure, flush and mid-fetch reset scenarios.
module tb_icon_operand_requester;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush_i;
  logic              fetch_valid_i;
  logic              fetch_ready_o;
  logic [ADDR_W-1:0] fetch_src0_addr_i;
  logic [ADDR_W-1:0] fetch_src1_addr_i;
  logic              fetch_src1_used_i;
  logic [ADDR_W-1:0] icon_tx_addr_o;
  logic              icon_tx_req_valid_o;
  logic [DATA_W-1:0] icon_tx_data_i;
  logic              icon_tx_success_i;
  logic [DATA_W-1:0] op0_data_o;
  logic [DATA_W-1:0] op1_data_o;
  logic              ops_valid_o;
  logic              ops_err_o;
  logic              ops_ready_i;

  int errors = 0;
  int checks = 0;

  icon_operand_requester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(15)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_src0_addr_i   (fetch_src0_addr_i),
    .fetch_src1_addr_i   (fetch_src1_addr_i),
    .fetch_src1_used_i   (fetch_src1_used_i),
    .icon_tx_addr_o      (icon_tx_addr_o),
    .icon_tx_req_valid_o (icon_tx_req_valid_o),
    .icon_tx_data_i      (icon_tx_data_i),
    .icon_tx_success_i   (icon_tx_success_i),
    .op0_data_o          (op0_data_o),
    .op1_data_o          (op1_data_o),
    .ops_valid_o         (ops_valid_o),
    .ops_err_o           (ops_err_o),
    .ops_ready_i         (ops_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic eerr);
    chk({tag, "_valid"}, 32'(ops_valid_o), 32'd1);
    chk({tag, "_op0"},   32'(op0_data_o),  32'(e0));
    chk({tag, "_op1"},   32'(op1_data_o),  32'(e1));
    chk({tag, "_err"},   32'(ops_err_o),   32'(eerr));
    chk({tag, "_req"},   32'(icon_tx_req_valid_o), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0;
    fetch_src0_addr_i = '0; fetch_src1_addr_i = '0; fetch_src1_used_i = 1'b0;
    icon_tx_data_i = '0; icon_tx_success_i = 1'b0; ops_ready_i = 1'b0;

    // reset state
    #12;
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_req",   32'(icon_tx_req_valid_o), 32'd0);
    chk("rst_valid", 32'(ops_valid_o), 32'd0);
    chk("rst_err",   32'(ops_err_o), 32'd0);
    chk("rst_addr",  32'(icon_tx_addr_o), 32'd0);
    reset_n = 1'b1;
    step();

    // zero-wait, two operands; success in IDLE must be ignored
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h12; fetch_src1_addr_i = 8'h34;
    fetch_src1_used_i = 1'b1; icon_tx_success_i = 1'b1; icon_tx_data_i = 16'hAAAA;
    step();
    chk("zw_t1_req",   32'(icon_tx_req_valid_o), 32'd1);
    chk("zw_t1_addr",  32'(icon_tx_addr_o), 32'h12);
    chk("zw_t1_ready", 32'(fetch_ready_o), 32'd0);
    chk("zw_t1_op0",   32'(op0_data_o), 32'h0);
    fetch_valid_i = 1'b0;
    step();
    chk("zw_t2_req",  32'(icon_tx_req_valid_o), 32'd1);
    chk("zw_t2_addr", 32'(icon_tx_addr_o), 32'h34);
    chk("zw_t2_valid", 32'(ops_valid_o), 32'd0);
    icon_tx_data_i = 16'h5555;
    step();
    chk_bundle("zw_t3", 16'hAAAA, 16'h5555, 1'b0);
    icon_tx_success_i = 1'b0; ops_ready_i = 1'b1;
    step();
    chk("zw_idle_valid", 32'(ops_valid_o), 32'd0);
    chk("zw_idle_ready", 32'(fetch_ready_o), 32'd1);
    ops_ready_i = 1'b0;

    // src1 unused, producer stalls 4 cycles then serves 0x00FF
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h56; fetch_src1_addr_i = 8'h78;
    fetch_src1_used_i = 1'b0; icon_tx_data_i = 16'h00FF;
    step();
    fetch_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st_req%0d", i),  32'(icon_tx_req_valid_o), 32'd1);
      chk($sformatf("st_addr%0d", i), 32'(icon_tx_addr_o), 32'h56);
      chk($sformatf("st_nv%0d", i),   32'(ops_valid_o), 32'd0);
      if (i == 4) icon_tx_success_i = 1'b1;
      step();
    end
    chk_bundle("st_done", 16'h00FF, 16'h0000, 1'b0);
    icon_tx_success_i = 1'b0; ops_ready_i = 1'b1;
    step();
    ops_ready_i = 1'b0;

    // timeout on operand 0: exactly 15 request cycles, src1 never requested
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h9A; fetch_src1_addr_i = 8'hBC;
    fetch_src1_used_i = 1'b1; icon_tx_data_i = 16'hDEAD;
    step();
    fetch_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_req%0d", i),  32'(icon_tx_req_valid_o), 32'd1);
      chk($sformatf("to_addr%0d", i), 32'(icon_tx_addr_o), 32'h9A);
      step();
    end
    chk_bundle("to_done", 16'h0000, 16'h0000, 1'b1);

    // backpressure in DONE with a new command waiting
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h11; fetch_src1_addr_i = 8'h22;
    fetch_src1_used_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bundle($sformatf("bp%0d", i), 16'h0000, 16'h0000, 1'b1);
      chk($sformatf("bp%0d_ready", i), 32'(fetch_ready_o), 32'd0);
    end
    ops_ready_i = 1'b1;
    step();
    chk("bp_idle_ready", 32'(fetch_ready_o), 32'd1);
    chk("bp_idle_valid", 32'(ops_valid_o), 32'd0);
    chk("bp_idle_req",   32'(icon_tx_req_valid_o), 32'd0);
    ops_ready_i = 1'b0;
    step();
    chk("bp_acc_req",  32'(icon_tx_req_valid_o), 32'd1);
    chk("bp_acc_addr", 32'(icon_tx_addr_o), 32'h11);
    fetch_valid_i = 1'b0;

    // flush in REQ0 coinciding with success: nothing captured
    flush_i = 1'b1; icon_tx_success_i = 1'b1; icon_tx_data_i = 16'hBEEF;
    step();
    chk("fl_req",   32'(icon_tx_req_valid_o), 32'd0);
    chk("fl_valid", 32'(ops_valid_o), 32'd0);
    chk("fl_ready", 32'(fetch_ready_o), 32'd1);
    chk("fl_op0",   32'(op0_data_o), 32'h0);
    flush_i = 1'b0; icon_tx_success_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), 32'(ops_valid_o), 32'd0);
    end
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h44; fetch_src1_addr_i = 8'h66;
    fetch_src1_used_i = 1'b1; icon_tx_success_i = 1'b1; icon_tx_data_i = 16'h1234;
    step();
    fetch_valid_i = 1'b0;
    chk("fr_addr0", 32'(icon_tx_addr_o), 32'h44);
    step();
    chk("fr_addr1", 32'(icon_tx_addr_o), 32'h66);
    icon_tx_data_i = 16'h4321;
    step();
    chk_bundle("fr_done", 16'h1234, 16'h4321, 1'b0);
    icon_tx_success_i = 1'b0; ops_ready_i = 1'b1;
    step();
    ops_ready_i = 1'b0;

    // asynchronous reset while operand 1 is pending
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h01; fetch_src1_addr_i = 8'h02;
    fetch_src1_used_i = 1'b1; icon_tx_success_i = 1'b1; icon_tx_data_i = 16'hCAFE;
    step();
    fetch_valid_i = 1'b0;
    step();
    chk("ar_req1_op0", 32'(op0_data_o), 32'hCAFE);
    chk("ar_req1_addr", 32'(icon_tx_addr_o), 32'h02);
    icon_tx_success_i = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req",   32'(icon_tx_req_valid_o), 32'd0);
    chk("ar_addr",  32'(icon_tx_addr_o), 32'd0);
    chk("ar_op0",   32'(op0_data_o), 32'd0);
    chk("ar_op1",   32'(op1_data_o), 32'd0);
    chk("ar_valid", 32'(ops_valid_o), 32'd0);
    chk("ar_err",   32'(ops_err_o), 32'd0);
    chk("ar_ready", 32'(fetch_ready_o), 32'd1);
    #2 reset_n = 1'b1;
    step();
    fetch_valid_i = 1'b1; fetch_src0_addr_i = 8'h0A; fetch_src1_used_i = 1'b0;
    icon_tx_success_i = 1'b1; icon_tx_data_i = 16'h0F0F;
    step();
    fetch_valid_i = 1'b0;
    chk("ap_req",  32'(icon_tx_req_valid_o), 32'd1);
    chk("ap_addr", 32'(icon_tx_addr_o), 32'h0A);
    step();
    chk_bundle("ap_done", 16'h0F0F, 16'h0000, 1'b0);
    icon_tx_success_i = 1'b0; ops_ready_i = 1'b1;
    step();
    chk("ap_idle", 32'(fetch_ready_o), 32'd1);
    ops_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
